// File: rtl/mod5_pkg.sv
// Shared definitions for the mod-5 seek controller: state encoding, counter
// geometry, direction constants and modular arithmetic helpers.
package mod5_pkg;

    localparam int MOD   = 5;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // (a - b) mod MOD for operands already in 0..MOD-1
    function automatic logic [CNT_W-1:0] mod5_dist(input logic [CNT_W-1:0] a,
                                                   input logic [CNT_W-1:0] b);
        logic [CNT_W:0] diff;
        diff = {1'b0, a} + (CNT_W+1)'(MOD) - {1'b0, b};
        if (diff >= (CNT_W+1)'(MOD)) begin
            diff = diff - (CNT_W+1)'(MOD);
        end
        return diff[CNT_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] mod5_next(input logic [CNT_W-1:0] cnt,
                                                   input logic             dir);
        logic [CNT_W-1:0] nxt;
        if (dir == DIR_UP) begin
            nxt = (cnt == CNT_W'(MOD - 1)) ? '0 : cnt + CNT_W'(1);
        end else begin
            nxt = (cnt == '0) ? CNT_W'(MOD - 1) : cnt - CNT_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mod5_counter.sv
// Mod-5 position counter; steps once per enabled cycle in the given direction,
// wrapping 4<->0.
module mod5_counter
    import mod5_pkg::*;
(
    input  logic             Clock,
    input  logic             Reset,
    input  logic             En,
    input  logic             Dir,
    output logic [CNT_W-1:0] Value
);

    logic [CNT_W-1:0] value_q;
    logic [CNT_W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (En) begin
            value_d = mod5_next(value_q, Dir);
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign Value = value_q;

endmodule

// File: rtl/mod5_seek_ctrl.sv
// Seek controller: moves a mod-5 counter to a requested target along the
// shortest (or forced upward) path, with abort, error and completion pulses.
module mod5_seek_ctrl
    import mod5_pkg::*;
(
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [CNT_W-1:0] Target,
    input  logic             Mode,
    input  logic             Abort,
    output logic [CNT_W-1:0] Count,
    output logic             Busy,
    output logic             Done,
    output logic             Err,
    output logic [CNT_W-1:0] Steps
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] steps_q, steps_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             cnt_en;
    logic [CNT_W-1:0] dist_up, dist_dn, dist_sel;

    mod5_counter u_counter (
        .Clock (Clock),
        .Reset (Reset),
        .En    (cnt_en),
        .Dir   (dir_q),
        .Value (Count)
    );

    assign dist_up = mod5_dist(Target, Count);
    assign dist_dn = mod5_dist(Count, Target);

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        dir_d    = dir_q;
        steps_d  = steps_q;
        err_d    = 1'b0;
        cnt_en   = 1'b0;
        dist_sel = '0;

        case (state_q)
            ST_IDLE: begin
                // Abort outranks Start: neither a seek nor an error is raised
                if (Start && !Abort) begin
                    if (Target > CNT_W'(MOD - 1)) begin
                        err_d = 1'b1;
                    end else begin
                        target_d = Target;
                        steps_d  = '0;
                        if (Mode || (dist_up <= dist_dn)) begin
                            dir_d    = DIR_UP;
                            dist_sel = dist_up;
                        end else begin
                            dir_d    = DIR_DOWN;
                            dist_sel = dist_dn;
                        end
                        state_d = (dist_sel == '0) ? ST_DONE : ST_STEP;
                    end
                end
            end
            ST_STEP: begin
                if (Abort) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_en  = 1'b1;
                    steps_d = steps_q + CNT_W'(1);
                    if (mod5_next(Count, dir_q) == target_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_STEP);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q  <= ST_IDLE;
            target_q <= '0;
            dir_q    <= DIR_UP;
            steps_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            dir_q    <= dir_d;
            steps_q  <= steps_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign Busy  = busy_q;
    assign Done  = done_q;
    assign Err   = err_q;
    assign Steps = steps_q;

endmodule

// File: tb/tb_mod5_seek_ctrl.sv
// Scoreboard bench for mod5_seek_ctrl: directed scenarios followed by random
// seeks, checked against an arithmetic model of the seek rules.
module tb_mod5_seek_ctrl;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Start;
    logic [2:0] Target;
    logic       Mode;
    logic       Abort;
    logic [2:0] Count;
    logic       Busy;
    logic       Done;
    logic       Err;
    logic [2:0] Steps;

    mod5_seek_ctrl dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .Start  (Start),
        .Target (Target),
        .Mode   (Mode),
        .Abort  (Abort),
        .Count  (Count),
        .Busy   (Busy),
        .Done   (Done),
        .Err    (Err),
        .Steps  (Steps)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        bit is_err;
        int cnt;
        int steps;
        int cyc;
        int busy;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   busy_run = 0;
    int   mc       = 0;  // model count
    int   ms       = 0;  // model steps

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every Done or Err pulse must match the oldest pending expectation
    always @(negedge Clock) begin
        if (Reset === 1'b1 && (Done || Err)) begin
            check("pending_expect", int'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check("out_kind_err", int'(Err), int'(mon_e.is_err));
                check("out_kind_done", int'(Done), int'(!mon_e.is_err));
                check("out_count", int'(Count), mon_e.cnt);
                check("out_steps", int'(Steps), mon_e.steps);
                check("out_cycle", cyc, mon_e.cyc);
                check("busy_cycles", busy_run, mon_e.busy);
            end
        end
        if (Busy) busy_run++;
        else      busy_run = 0;
    end

    task automatic junk_inputs();
        Start  = 1'($urandom_range(0, 1));
        Target = 3'($urandom_range(0, 7));
        Mode   = 1'($urandom_range(0, 1));
    endtask

    // Called just after a negedge; returns just after a negedge with Start low.
    task automatic seek(input int t, input int m, input int abort_k);
        int up, dn, d, k;
        bit go_up;
        exp_t e;
        Start  = 1'b1;
        Abort  = 1'b0;
        Target = 3'(t);
        Mode   = 1'(m);
        if (t > 4) begin
            e = '{1'b1, mc, ms, cyc + 1, 0};
            sb_q.push_back(e);
            @(negedge Clock);
            Start = 1'b0;
            return;
        end
        up    = (t - mc + 5) % 5;
        dn    = (mc - t + 5) % 5;
        go_up = (m != 0) || (up <= dn);
        d     = go_up ? up : dn;
        if (abort_k == 0 || d == 0) begin
            e = '{1'b0, t, d, cyc + 1 + d, d};
            sb_q.push_back(e);
            for (int i = 0; i <= d; i++) begin
                @(negedge Clock);
                junk_inputs();
            end
            @(negedge Clock);
            Start = 1'b0;
            mc = t;
            ms = d;
            check("idle_after_done_busy", int'(Busy), 0);
        end else begin
            k = (abort_k > d) ? d : abort_k;
            for (int j = 1; j <= k; j++) begin
                @(negedge Clock);
                if (j == k) begin
                    Start = 1'b0;
                    Abort = 1'b1;
                end else begin
                    junk_inputs();
                end
            end
            @(negedge Clock);
            Abort = 1'b0;
            Start = 1'b0;
            ms = k - 1;
            mc = go_up ? (mc + k - 1) % 5 : (mc - (k - 1) + 5) % 5;
            check("abort_count", int'(Count), mc);
            check("abort_steps", int'(Steps), ms);
            check("abort_busy", int'(Busy), 0);
            check("abort_done", int'(Done), 0);
        end
    endtask

    task automatic abort_in_idle();
        Start  = 1'b1;
        Abort  = 1'b1;
        Target = 3'($urandom_range(0, 7));
        @(negedge Clock);
        Start = 1'b0;
        Abort = 1'b0;
        check("idle_abort_busy", int'(Busy), 0);
        check("idle_abort_err", int'(Err), 0);
        check("idle_abort_count", int'(Count), mc);
    endtask

    task automatic reset_mid_seek();
        Start  = 1'b1;
        Abort  = 1'b0;
        Target = 3'((mc + 3) % 5);
        Mode   = 1'b1;
        @(negedge Clock);
        junk_inputs();
        @(negedge Clock);
        Reset = 1'b0;
        Start = 1'b0;
        @(negedge Clock);
        check("rst_mid_count", int'(Count), 0);
        check("rst_mid_steps", int'(Steps), 0);
        check("rst_mid_busy", int'(Busy), 0);
        check("rst_mid_done", int'(Done), 0);
        check("rst_mid_err", int'(Err), 0);
        Reset = 1'b1;
        mc = 0;
        ms = 0;
    endtask

    initial begin
        int r;
        Reset  = 1'b0;
        Start  = 1'b0;
        Target = 3'd0;
        Mode   = 1'b0;
        Abort  = 1'b0;
        repeat (3) @(negedge Clock);
        check("reset_count", int'(Count), 0);
        check("reset_steps", int'(Steps), 0);
        check("reset_busy", int'(Busy), 0);
        check("reset_done", int'(Done), 0);
        check("reset_err", int'(Err), 0);

        Reset = 1'b1;
        seek(3, 0, 0);          // shortest path downward: 0 -> 4 -> 3
        seek(0, 0, 0);
        seek(3, 1, 0);          // forced up: 0 -> 1 -> 2 -> 3
        seek(2, 0, 0);
        seek(2, 0, 0);          // zero distance
        seek(6, 0, 0);          // illegal target
        seek(0, 1, 0);
        seek(4, 1, 2);          // abort in second step cycle
        abort_in_idle();
        reset_mid_seek();
        seek(1, 0, 0);

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                abort_in_idle();
            end else begin
                seek($urandom_range(0, 6), $urandom_range(0, 1),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
            end
        end

        repeat (4) @(negedge Clock);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
